pipeline_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage RV64 pipeline (IF/ID/EX/MEM/WB). It keeps a shadow copy of destination-register information for the EX, MEM and WB stages. From that it generates the pipeline stall, flush and freeze controls, plus the registered EX-stage operand-forwarding selects. It also handles a variable-latency data-memory handshake with a timeout, and provides stall and flush performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV64 pipeline: stall/flush/freeze,
// registered EX forwarding selects, data-memory wait timeout and perf counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_rf_wr_en_i,
  input  logic             id_is_load_i,
  input  logic             id_is_mem_i,
  input  logic             ex_branch_taken_i,
  input  logic             dm_ready_i,
  output logic             pc_stall_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             freeze_o,
  output logic [1:0]       fwd_a_sel_o,
  output logic [1:0]       fwd_b_sel_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] perf_stall_cnt_o,
  output logic [CNT_W-1:0] perf_flush_cnt_o
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wrEn;
    logic       isLoad;
    logic       isMem;
  } shadow_t;

  typedef enum logic [0:0] {RUN, MEM_WAIT} state_e;

  shadow_t           exStage_q, memStage_q, wbStage_q, exStage_d;
  state_e            state_q, state_d;
  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
  logic              memErr_q, memErr_d;
  logic [1:0]        fwdA_q, fwdB_q, fwdA_d, fwdB_d;
  logic [CNT_W-1:0]  stallCnt_q, flushCnt_q;
  logic              freeze, branchFlush, loadUse;

  function automatic logic hazardMatch(shadow_t s, logic [4:0] rs, logic useRs);
    return s.valid & s.wrEn & (s.rd != 5'd0) & (s.rd == rs) & useRs;
  endfunction

  // A load sitting in EX never forwards; the load-use stall handles it instead.
  function automatic logic [1:0] fwdSelect(shadow_t ex, shadow_t mem, logic [4:0] rs, logic useRs);
    logic [1:0] sel;
    sel = 2'b00;
    if (hazardMatch(ex, rs, useRs) && !ex.isLoad) sel = 2'b01;
    else if (hazardMatch(mem, rs, useRs))          sel = 2'b10;
    return sel;
  endfunction

  always_comb begin
    freeze      = 1'b0;
    branchFlush = 1'b0;
    loadUse     = 1'b0;
    if (!reset_i) begin
      freeze      = memStage_q.valid & memStage_q.isMem & ~dm_ready_i;
      branchFlush = ~freeze & ex_branch_taken_i;
      loadUse     = ~freeze & ~ex_branch_taken_i & id_valid_i & exStage_q.isLoad &
                    (hazardMatch(exStage_q, id_rs1_i, id_use_rs1_i) |
                     hazardMatch(exStage_q, id_rs2_i, id_use_rs2_i));
    end
  end

  assign freeze_o     = freeze;
  assign pc_stall_o   = freeze | loadUse;
  assign ifid_stall_o = freeze | loadUse;
  assign ifid_flush_o = branchFlush;
  assign idex_flush_o = branchFlush | loadUse;

  always_comb begin
    exStage_d.valid  = id_valid_i & ~idex_flush_o;
    exStage_d.rd     = id_rd_i;
    exStage_d.wrEn   = id_rf_wr_en_i;
    exStage_d.isLoad = id_is_load_i;
    exStage_d.isMem  = id_is_mem_i;
    fwdA_d = 2'b00;
    fwdB_d = 2'b00;
    if (id_valid_i && !idex_flush_o) begin
      fwdA_d = fwdSelect(exStage_q, memStage_q, id_rs1_i, id_use_rs1_i);
      fwdB_d = fwdSelect(exStage_q, memStage_q, id_rs2_i, id_use_rs2_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      exStage_q  <= '0;
      memStage_q <= '0;
      wbStage_q  <= '0;
      fwdA_q     <= 2'b00;
      fwdB_q     <= 2'b00;
    end else if (!freeze) begin
      exStage_q  <= exStage_d;
      memStage_q <= exStage_q;
      wbStage_q  <= memStage_q;
      fwdA_q     <= fwdA_d;
      fwdB_q     <= fwdB_d;
    end
  end

  // Wait counter saturates at the timeout so mem_err stays meaningful on long stalls.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = '0;
    memErr_d  = memErr_q;
    case (state_q)
      RUN: begin
        if (freeze) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (dm_ready_i) begin
          state_d = RUN;
        end else begin
          waitCnt_d = (waitCnt_q == TIMEOUT_VAL) ? waitCnt_q : waitCnt_q + WAIT_W'(1);
          if (waitCnt_d == TIMEOUT_VAL) memErr_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= RUN;
      waitCnt_q  <= '0;
      memErr_q   <= 1'b0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      memErr_q  <= memErr_d;
      if (pc_stall_o)  stallCnt_q <= stallCnt_q + CNT_W'(1);
      if (branchFlush) flushCnt_q <= flushCnt_q + CNT_W'(1);
    end
  end

  assign fwd_a_sel_o      = fwdA_q;
  assign fwd_b_sel_o      = fwdB_q;
  assign mem_err_o        = memErr_q;
  assign perf_stall_cnt_o = stallCnt_q;
  assign perf_flush_cnt_o = flushCnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: table of per-cycle vectors plus hand-built
// timeout and reset-abort sequences, checked through an expectation queue.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned CNT_W       = 32;

  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_STALL = 5'b11010;
  localparam logic [4:0] C_FLUSH = 5'b00110;
  localparam logic [4:0] C_FRZ   = 5'b11001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             idValid, idUseRs1, idUseRs2, idWrEn, idIsLoad, idIsMem;
  logic [4:0]       idRs1, idRs2, idRd;
  logic             exBranchTaken, dmReady;
  logic             pcStall, ifidStall, ifidFlush, idexFlush, freeze, memErr;
  logic [1:0]       fwdA, fwdB;
  logic [CNT_W-1:0] stallCnt, flushCnt;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .id_valid_i       (idValid),
    .id_rs1_i         (idRs1),
    .id_rs2_i         (idRs2),
    .id_use_rs1_i     (idUseRs1),
    .id_use_rs2_i     (idUseRs2),
    .id_rd_i          (idRd),
    .id_rf_wr_en_i    (idWrEn),
    .id_is_load_i     (idIsLoad),
    .id_is_mem_i      (idIsMem),
    .ex_branch_taken_i(exBranchTaken),
    .dm_ready_i       (dmReady),
    .pc_stall_o       (pcStall),
    .ifid_stall_o     (ifidStall),
    .ifid_flush_o     (ifidFlush),
    .idex_flush_o     (idexFlush),
    .freeze_o         (freeze),
    .fwd_a_sel_o      (fwdA),
    .fwd_b_sel_o      (fwdB),
    .mem_err_o        (memErr),
    .perf_stall_cnt_o (stallCnt),
    .perf_flush_cnt_o (flushCnt)
  );

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       mem;
  } inst_t;

  typedef struct {
    logic       rst;
    inst_t      ins;
    logic       br;
    logic       dmr;
    logic [4:0] ctl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  vec_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;
  logic [CNT_W-1:0] expStall = '0;
  logic [CNT_W-1:0] expFlush = '0;

  function automatic inst_t nop();
    return '0;
  endfunction

  function automatic inst_t alu(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return '{valid:1'b1, rs1:rs1, rs2:rs2, use1:1'b1, use2:1'b1, rd:rd, wr:1'b1, ld:1'b0, mem:1'b0};
  endfunction

  function automatic inst_t alu1(logic [4:0] rd, logic [4:0] rs1);
    return '{valid:1'b1, rs1:rs1, rs2:5'd0, use1:1'b1, use2:1'b0, rd:rd, wr:1'b1, ld:1'b0, mem:1'b0};
  endfunction

  function automatic inst_t ldi(logic [4:0] rd, logic [4:0] rs1);
    return '{valid:1'b1, rs1:rs1, rs2:5'd0, use1:1'b1, use2:1'b0, rd:rd, wr:1'b1, ld:1'b1, mem:1'b1};
  endfunction

  function automatic inst_t sti(logic [4:0] rs1, logic [4:0] rs2);
    return '{valid:1'b1, rs1:rs1, rs2:rs2, use1:1'b1, use2:1'b1, rd:5'd0, wr:1'b0, ld:1'b0, mem:1'b1};
  endfunction

  function automatic inst_t bri(logic [4:0] rs1, logic [4:0] rs2);
    return '{valid:1'b1, rs1:rs1, rs2:rs2, use1:1'b1, use2:1'b1, rd:5'd0, wr:1'b0, ld:1'b0, mem:1'b0};
  endfunction

  function automatic vec_t mk(logic rst, inst_t i, logic br, logic dmr, logic [4:0] ctl,
                              logic [1:0] fa, logic [1:0] fb, logic err);
    vec_t v;
    v.rst = rst; v.ins = i; v.br = br; v.dmr = dmr;
    v.ctl = ctl; v.fa = fa; v.fb = fb; v.err = err;
    return v;
  endfunction

  task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL step%0d %s actual=%0h required=%0h", step, name, act, req);
    end
  endtask

  // Inputs change on the falling edge so the DUT sees them stable at the next rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    reset         = v.rst;
    idValid       = v.ins.valid;
    idRs1         = v.ins.rs1;
    idRs2         = v.ins.rs2;
    idUseRs1      = v.ins.use1;
    idUseRs2      = v.ins.use2;
    idRd          = v.ins.rd;
    idWrEn        = v.ins.wr;
    idIsLoad      = v.ins.ld;
    idIsMem       = v.ins.mem;
    exBranchTaken = v.br;
    dmReady       = v.dmr;
    expQ.push_back(v);
  endtask

  // Counters show everything up to the previous edge, so compare before accumulating.
  task automatic checkOutput();
    vec_t e;
    #2;
    if (expQ.size() == 0) begin
      compareVal("queue_empty", 32'd1, 32'd0);
    end else begin
      e = expQ.pop_front();
      compareVal("ctl{pc,ifid_stall,ifid_flush,idex_flush,freeze}",
                 {27'd0, pcStall, ifidStall, ifidFlush, idexFlush, freeze}, {27'd0, e.ctl});
      compareVal("fwd_a_sel", {30'd0, fwdA}, {30'd0, e.fa});
      compareVal("fwd_b_sel", {30'd0, fwdB}, {30'd0, e.fb});
      compareVal("mem_err", {31'd0, memErr}, {31'd0, e.err});
      compareVal("perf_stall_cnt", stallCnt, expStall);
      compareVal("perf_flush_cnt", flushCnt, expFlush);
      if (e.rst) begin
        expStall = '0;
        expFlush = '0;
      end else begin
        expStall = expStall + CNT_W'(e.ctl[4]);
        expFlush = expFlush + CNT_W'(e.ctl[2]);
      end
    end
    step++;
  endtask

  task automatic runVec(input vec_t v);
    applyStimulus(v);
    checkOutput();
  endtask

  initial begin
    reset = 1'b1; idValid = 1'b0; idRs1 = '0; idRs2 = '0; idUseRs1 = 1'b0; idUseRs2 = 1'b0;
    idRd = '0; idWrEn = 1'b0; idIsLoad = 1'b0; idIsMem = 1'b0;
    exBranchTaken = 1'b0; dmReady = 1'b1;

    // reset, then back-to-back, one-apart, x0 and EX-over-MEM forwarding
    vecs.push_back(mk(1, nop(),           0, 1, C_NONE, 2'b00, 2'b00, 0));
    vecs.push_back(mk(1, nop(),           0, 1, C_NONE, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, alu(5, 1, 2),    0, 1, C_NONE, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, alu(6, 5, 5),    0, 1, C_NONE, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, nop(),           0, 1, C_NONE, 2'b01, 2'b01, 0));
    vecs.push_back(mk(0, alu(9, 1, 2),    0, 1, C_NONE, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, alu(10, 1, 2),   0, 1, C_NONE, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, alu(11, 9, 9),   0, 1, C_NONE, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, alu(0, 1, 2),    0, 1, C_NONE, 2'b10, 2'b10, 0));
    vecs.push_back(mk(0, alu(12, 0, 0),   0, 1, C_NONE, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, alu(13, 0, 0),   0, 1, C_NONE, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, alu(14, 13, 12), 0, 1, C_NONE, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, nop(),           0, 1, C_NONE, 2'b01, 2'b10, 0));
    vecs.push_back(mk(0, nop(),           0, 1, C_NONE, 2'b00, 2'b00, 0));
    // load-use: one bubble, then MEM forwarding
    vecs.push_back(mk(0, ldi(5, 1),       0, 1, C_NONE,  2'b00, 2'b00, 0));
    vecs.push_back(mk(0, alu1(6, 5),      0, 1, C_STALL, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, alu1(6, 5),      0, 1, C_NONE,  2'b00, 2'b00, 0));
    vecs.push_back(mk(0, nop(),           0, 1, C_NONE,  2'b10, 2'b00, 0));
    vecs.push_back(mk(0, nop(),           0, 1, C_NONE,  2'b00, 2'b00, 0));
    // branch flush suppresses a pending load-use stall
    vecs.push_back(mk(0, ldi(7, 1),       0, 1, C_NONE,  2'b00, 2'b00, 0));
    vecs.push_back(mk(0, alu(8, 7, 7),    1, 1, C_FLUSH, 2'b00, 2'b00, 0));
    vecs.push_back(mk(0, nop(),           0, 1, C_NONE,  2'b00, 2'b00, 0));
    // store stalls in MEM for 3 cycles with a taken branch held in EX
    vecs.push_back(mk(0, alu(5, 1, 2),    0, 1, C_NONE,  2'b00, 2'b00, 0));
    vecs.push_back(mk(0, sti(5, 6),       0, 1, C_NONE,  2'b00, 2'b00, 0));
    vecs.push_back(mk(0, bri(5, 1),       0, 1, C_NONE,  2'b01, 2'b00, 0));
    vecs.push_back(mk(0, alu(9, 5, 1),    1, 0, C_FRZ,   2'b10, 2'b00, 0));
    vecs.push_back(mk(0, alu(9, 5, 1),    1, 0, C_FRZ,   2'b10, 2'b00, 0));
    vecs.push_back(mk(0, alu(9, 5, 1),    1, 0, C_FRZ,   2'b10, 2'b00, 0));
    vecs.push_back(mk(0, alu(9, 5, 1),    1, 1, C_FLUSH, 2'b10, 2'b00, 0));
    vecs.push_back(mk(0, nop(),           0, 1, C_NONE,  2'b00, 2'b00, 0));
    vecs.push_back(mk(0, nop(),           0, 1, C_NONE,  2'b00, 2'b00, 0));

    foreach (vecs[i]) runVec(vecs[i]);

    // timeout: 6 pending cycles; the 4th MEM_WAIT cycle sets mem_err, visible on the next
    runVec(mk(0, sti(1, 2), 0, 1, C_NONE, 2'b00, 2'b00, 0));
    runVec(mk(0, nop(),     0, 1, C_NONE, 2'b00, 2'b00, 0));
    for (int i = 0; i < 6; i++)
      runVec(mk(0, nop(), 0, 0, C_FRZ, 2'b00, 2'b00, (i == 5)));
    runVec(mk(0, nop(),     0, 1, C_NONE, 2'b00, 2'b00, 1));
    runVec(mk(0, nop(),     0, 1, C_NONE, 2'b00, 2'b00, 1));

    // reset in the middle of a memory wait
    runVec(mk(0, sti(1, 2), 0, 1, C_NONE, 2'b00, 2'b00, 1));
    runVec(mk(0, nop(),     0, 1, C_NONE, 2'b00, 2'b00, 1));
    runVec(mk(0, nop(),     0, 0, C_FRZ,  2'b00, 2'b00, 1));
    runVec(mk(0, nop(),     0, 0, C_FRZ,  2'b00, 2'b00, 1));
    runVec(mk(1, nop(),     0, 0, C_NONE, 2'b00, 2'b00, 1));
    runVec(mk(0, nop(),     0, 0, C_NONE, 2'b00, 2'b00, 0));
    runVec(mk(0, nop(),     0, 1, C_NONE, 2'b00, 2'b00, 0));

    if (expQ.size() != 0) compareVal("queue_leftover", expQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
